// File: rtl/fpq_frame_queue_if.sv
// fpq_frame_queue_if: descriptor push, window budget, arbiter grant and
// transmit status bundle for one per-class egress frame queue.
interface fpq_frame_queue_if #(
    parameter int AW = 3,
    parameter int LEN_W = 8
);
    logic             wr_en;
    logic [LEN_W-1:0] wr_len;
    logic             drop;
    logic             full;
    logic             empty;
    logic [AW:0]      level;
    logic [LEN_W-1:0] cur_value;
    logic             ena_n;
    logic [LEN_W-1:0] pkt_len;
    logic             bool_ready;
    logic             bool_go;
    logic [LEN_W-1:0] units_left;
    logic             tx_done;
    logic             aborted;

    modport master (
        output wr_en, wr_len, cur_value, ena_n,
        input  drop, full, empty, level, pkt_len, bool_ready, bool_go, units_left, tx_done, aborted
    );
    modport slave (
        input  wr_en, wr_len, cur_value, ena_n,
        output drop, full, empty, level, pkt_len, bool_ready, bool_go, units_left, tx_done, aborted
    );
endinterface

// File: rtl/fpq_frame_queue.sv
// fpq_frame_queue: circular queue of frame lengths (16 B units) that reports
// window readiness and, on grant, transmits the head frame for its exact duration.
module fpq_frame_queue #(
    parameter int AW = 3,
    parameter int LEN_W = 8,
    parameter int UNIT_TICKS = 16
) (
    input logic clk,
    input logic rst,
    fpq_frame_queue_if.slave q
);
    localparam int DEPTH = 2 ** AW;
    localparam int UW = $clog2(UNIT_TICKS);
    localparam int CW = LEN_W + UW;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PAUSE, S_GO} state_t;

    state_t           state;
    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [AW:0]      level;
    logic [CW-1:0]    tx_cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             drop;
    logic             go;
    logic             done;
    logic             abrt;
    logic [LEN_W-1:0] pkt_len;

    assign full    = level == DEPTH_L;
    assign empty   = level == '0;
    assign pkt_len = empty ? '0 : mem[rd_ptr];
    assign push    = q.wr_en & !full & (q.wr_len != '0);
    assign pop     = (state == S_GO) & !q.ena_n & (tx_cnt == '0);

    assign q.full       = full;
    assign q.empty      = empty;
    assign q.level      = level;
    assign q.drop       = drop;
    assign q.pkt_len    = pkt_len;
    assign q.bool_ready = (state == S_IDLE) & !empty & (q.cur_value >= pkt_len);
    assign q.bool_go    = go;
    assign q.units_left = (state == S_GO) ? tx_cnt[CW-1:UW] : '0;
    assign q.tx_done    = done;
    assign q.aborted    = abrt;

    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= q.wr_len;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
            drop   <= 1'b0;
        end else begin
            drop <= q.wr_en & !push;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            if (push & !pop) level <= level + (AW + 1)'(1);
            else if (pop & !push) level <= level - (AW + 1)'(1);
        end

    // Abort is tested before completion so a withdrawn grant never pops.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= S_IDLE;
            tx_cnt <= '0;
            go     <= 1'b0;
            done   <= 1'b0;
            abrt   <= 1'b0;
        end else begin
            done <= 1'b0;
            abrt <= 1'b0;
            case (state)
                S_IDLE:
                    if (!q.ena_n && !empty) begin
                        tx_cnt <= (CW'(pkt_len) << UW) - CW'(1);
                        state  <= S_PAUSE;
                    end
                S_PAUSE: begin
                    state <= q.ena_n ? S_IDLE : S_GO;
                    go    <= !q.ena_n;
                end
                S_GO:
                    if (q.ena_n) begin
                        state <= S_IDLE;
                        go    <= 1'b0;
                        abrt  <= 1'b1;
                    end else if (tx_cnt == '0) begin
                        state <= S_IDLE;
                        go    <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        tx_cnt <= tx_cnt - CW'(1);
                    end
                default: state <= S_IDLE;
            endcase
        end
endmodule
